encoder_rx_decoder: RTL and testbench
=====================================

ENCODER_RX_DECODER -- requirements
Module: encoder_rx_decoder

Interface
REQ-001 The block SHALL have a single clock domain and a single reset.
REQ-002 clock  input  1  rising-edge clock, one symbol quartet per cycle.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces all state and outputs to reset values.
REQ-004 io_A, io_B, io_C, io_D  input  3 each  received PAM5 symbols, 3-bit two's complement.
REQ-005 io_loc_rcvr_status  input  1  local receiver OK; low aborts and holds the decoder in IDLE.
REQ-006 io_rx_dv  output  1  decoded byte valid.
REQ-007 io_rx_er  output  1  decoded byte in error.
REQ-008 io_rx_data  output  8  decoded byte.
REQ-009 io_frame_end  output  1  one-cycle pulse on end-of-frame.
REQ-010 io_ext  output  2  ESD2 code, valid with io_frame_end: 0=Ext_0, 1=Ext_1, 2=Ext_2, 3=Ext_Err.
REQ-011 io_frame_count  output  16  frames closed with Ext_0/1/2, wraps 0xFFFF->0.
REQ-012 io_err_count  output  16  frames with any error, wraps 0xFFFF->0.

Function
REQ-013 Symbol codes SHALL be: -2=110, -1=111, 0=000, +1=001, +2=010; codes 011, 100 and 101 are invalid.
REQ-014 Data decode SHALL map each symbol to 2 bits: 0->00, +1->01, -1->10, +2->11; A->[7:6], B->[5:4], C->[3:2], D->[1:0]. A quartet containing -2 or an invalid code is not data.
REQ-015 Control quartets (A,B,C,D) SHALL be: SSD1=ESD1=(+2,+2,+2,+2); SSD2=ESD2_Ext_0=(+2,+2,+2,-2); Ext_1=(+2,+2,-2,+2); Ext_2=(+2,-2,+2,+2); Ext_Err=(-2,+2,+2,+2).
REQ-016 States SHALL be IDLE, SSD_WAIT, DATA and ESD_WAIT; the reset state is IDLE.
REQ-017 IDLE: SSD1 -> SSD_WAIT; any other quartet -> IDLE.
REQ-018 SSD_WAIT: SSD2 -> DATA; SSD1 -> stay in SSD_WAIT; any other quartet -> IDLE with no output.
REQ-019 DATA: a data quartet (other than all +2) SHALL emit its byte; an all-+2 quartet SHALL be held and the state SHALL move to ESD_WAIT; a non-data quartet SHALL emit io_rx_er=1 with io_rx_data=0x00 and the state SHALL stay in DATA.
REQ-020 ESD_WAIT, ESD2 variant: the held quartet SHALL be discarded, io_frame_end SHALL pulse with io_ext set, and the state SHALL go to IDLE.
REQ-021 ESD_WAIT, all-+2 quartet: emit 0xFF for the held quartet and stay in ESD_WAIT.
REQ-022 ESD_WAIT, other data quartet: emit 0xFF, then that byte, and go to DATA.
REQ-023 ESD_WAIT, other non-data quartet: emit 0xFF, then an error byte, and go to DATA.
REQ-024 Latency SHALL be fixed at 2: the output for the quartet sampled at edge k SHALL be driven after edge k+2, and io_frame_end SHALL be driven after edge k+2 where k is the ESD1 quartet.
REQ-025 io_rx_dv SHALL be contiguous from the first data byte to the last; it SHALL be 0 in the io_frame_end cycle.
REQ-026 io_frame_count SHALL increment on Ext_0/1/2.
REQ-027 io_err_count SHALL increment once per frame that has any io_rx_er, an Ext_Err end, or an abort, at frame end or abort.
REQ-028 io_loc_rcvr_status=0 SHALL force IDLE next edge and flush the pipeline; if mid-frame, one cycle of io_rx_dv=0, io_rx_er=1 is output, with no io_frame_end and no frame_count increment.
REQ-029 SSD1 or SSD2 appearing inside DATA SHALL NOT restart the frame; these quartets follow the REQ-019 and REQ-020 rules.

Reset
REQ-030 While reset is low, all outputs SHALL be 0, counters SHALL be 0, the state SHALL be IDLE and the pipeline SHALL be empty.
REQ-031 Reset asserted mid-frame SHALL drop io_rx_dv asynchronously; no frame end is reported.
REQ-032 After reset deasserts, the first SSD1 SHALL be recognised on the first rising edge.

Verification
REQ-033 Input SSD1, SSD2, then (-1,-1,+1,+1), (0,0,0,0), ESD1, Ext_0 -> io_rx_data 0xA5 then 0x00 with io_rx_dv=1 for 2 cycles; io_frame_end=1 with io_ext=0; io_frame_count=1.
REQ-034 Input SSD1, SSD2, (+2,+2,+2,+2), (0,0,0,+1), ESD1, Ext_2 -> io_rx_data 0xFF then 0x01; io_ext=2; io_err_count=0.
REQ-035 Input SSD1, SSD2, (011,0,0,0), ESD1, Ext_Err -> error byte with io_rx_er=1 and io_rx_data=0x00; io_ext=3; io_frame_count=0; io_err_count=1.
REQ-036 Input SSD1, SSD2, then data 0x12 with io_loc_rcvr_status dropped on the data cycle -> io_rx_dv never asserted for 0x12; one io_rx_er pulse; io_err_count=1.
REQ-037 Input SSD1, SSD1, SSD2, 0x3C, ESD1, Ext_1 -> 0x3C decoded; io_ext=1. Input SSD1 followed by (0,0,0,0) -> no io_rx_dv.
REQ-038 Drive 65536 good frames -> io_frame_count wraps to 0.

Source files
------------

// File: rtl/encoder_rx_decoder.sv
// rtl/encoder_rx_decoder.sv - PAM5 receive decoder: SSD/ESD framing to byte stream, fixed 2-cycle latency
module encoder_rx_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  io_A,
  input  logic [2:0]  io_B,
  input  logic [2:0]  io_C,
  input  logic [2:0]  io_D,
  input  logic        io_loc_rcvr_status,
  output logic        io_rx_dv,
  output logic        io_rx_er,
  output logic [7:0]  io_rx_data,
  output logic        io_frame_end,
  output logic [1:0]  io_ext,
  output logic [15:0] io_frame_count,
  output logic [15:0] io_err_count
);

  typedef enum logic [1:0] {IDLE, SSD_WAIT, DATA, ESD_WAIT} state_t;

  localparam logic [2:0] SYM_P2 = 3'b010;
  localparam logic [2:0] SYM_M2 = 3'b110;

  state_t      state, state_n;
  logic [11:0] q_quartet;
  logic        q_ok;

  // s1 holds the decoded result of the previous quartet; the output register is the second stage
  logic        s1_dv, s1_er, s1_dv_n, s1_er_n;
  logic [7:0]  s1_data, s1_data_n;
  logic        out_dv_n, out_er_n, out_fe_n;
  logic [7:0]  out_data_n;
  logic [1:0]  out_ext_n;

  logic        frame_err, frame_err_n;
  logic        frame_inc, err_inc;
  logic [15:0] frame_cnt, err_cnt;

  logic [2:0]  dec_a, dec_b, dec_c, dec_d;
  logic        d_ok, all_p2, esd2;
  logic [7:0]  d_byte;
  logic [1:0]  esd_ext;

  // {valid, bits}: 0->00, +1->01, -1->10, +2->11; -2 and invalid codes are not data
  function automatic logic [2:0] sym_decode(input logic [2:0] s);
    case (s)
      3'b000:  sym_decode = 3'b100;
      3'b001:  sym_decode = 3'b101;
      3'b111:  sym_decode = 3'b110;
      3'b010:  sym_decode = 3'b111;
      default: sym_decode = 3'b000;
    endcase
  endfunction

  always_comb begin
    dec_a  = sym_decode(q_quartet[11:9]);
    dec_b  = sym_decode(q_quartet[8:6]);
    dec_c  = sym_decode(q_quartet[5:3]);
    dec_d  = sym_decode(q_quartet[2:0]);
    d_ok   = dec_a[2] & dec_b[2] & dec_c[2] & dec_d[2];
    d_byte = {dec_a[1:0], dec_b[1:0], dec_c[1:0], dec_d[1:0]};
    all_p2 = (q_quartet == {SYM_P2, SYM_P2, SYM_P2, SYM_P2});
  end

  always_comb begin
    esd2    = 1'b1;
    esd_ext = 2'd0;
    case (q_quartet)
      {SYM_P2, SYM_P2, SYM_P2, SYM_M2}: esd_ext = 2'd0;
      {SYM_P2, SYM_P2, SYM_M2, SYM_P2}: esd_ext = 2'd1;
      {SYM_P2, SYM_M2, SYM_P2, SYM_P2}: esd_ext = 2'd2;
      {SYM_M2, SYM_P2, SYM_P2, SYM_P2}: esd_ext = 2'd3;
      default:                          esd2    = 1'b0;
    endcase
  end

  always_comb begin
    state_n     = state;
    s1_dv_n     = 1'b0;
    s1_er_n     = 1'b0;
    s1_data_n   = 8'h00;
    out_dv_n    = s1_dv;
    out_er_n    = s1_er;
    out_data_n  = s1_data;
    out_fe_n    = 1'b0;
    out_ext_n   = 2'd0;
    frame_err_n = frame_err;
    frame_inc   = 1'b0;
    err_inc     = 1'b0;

    if (!q_ok) begin
      // abort: flush both stages; a frame in progress gets a single error marker
      state_n     = IDLE;
      out_dv_n    = 1'b0;
      out_er_n    = 1'b0;
      out_data_n  = 8'h00;
      frame_err_n = 1'b0;
      if (state == DATA || state == ESD_WAIT) begin
        out_er_n = 1'b1;
        err_inc  = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          frame_err_n = 1'b0;
          if (all_p2) state_n = SSD_WAIT;
        end
        SSD_WAIT: begin
          if (esd2 && esd_ext == 2'd0) state_n = DATA;
          else if (!all_p2)            state_n = IDLE;
        end
        DATA: begin
          if (all_p2) begin
            state_n = ESD_WAIT;
          end else if (d_ok) begin
            s1_dv_n   = 1'b1;
            s1_data_n = d_byte;
          end else begin
            s1_dv_n     = 1'b1;
            s1_er_n     = 1'b1;
            frame_err_n = 1'b1;
          end
        end
        ESD_WAIT: begin
          if (esd2) begin
            state_n     = IDLE;
            out_dv_n    = 1'b0;
            out_er_n    = 1'b0;
            out_data_n  = 8'h00;
            out_fe_n    = 1'b1;
            out_ext_n   = esd_ext;
            frame_inc   = (esd_ext != 2'd3);
            err_inc     = (esd_ext == 2'd3) || frame_err;
            frame_err_n = 1'b0;
          end else begin
            // the held all-+2 quartet turned out to be data
            out_dv_n   = 1'b1;
            out_er_n   = 1'b0;
            out_data_n = 8'hFF;
            if (!all_p2) begin
              state_n = DATA;
              s1_dv_n = 1'b1;
              if (d_ok) begin
                s1_data_n = d_byte;
              end else begin
                s1_er_n     = 1'b1;
                frame_err_n = 1'b1;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      q_quartet    <= 12'h000;
      q_ok         <= 1'b0;
      s1_dv        <= 1'b0;
      s1_er        <= 1'b0;
      s1_data      <= 8'h00;
      io_rx_dv     <= 1'b0;
      io_rx_er     <= 1'b0;
      io_rx_data   <= 8'h00;
      io_frame_end <= 1'b0;
      io_ext       <= 2'd0;
      frame_err    <= 1'b0;
      frame_cnt    <= 16'd0;
      err_cnt      <= 16'd0;
    end else begin
      state        <= state_n;
      q_quartet    <= {io_A, io_B, io_C, io_D};
      q_ok         <= io_loc_rcvr_status;
      s1_dv        <= s1_dv_n;
      s1_er        <= s1_er_n;
      s1_data      <= s1_data_n;
      io_rx_dv     <= out_dv_n;
      io_rx_er     <= out_er_n;
      io_rx_data   <= out_data_n;
      io_frame_end <= out_fe_n;
      io_ext       <= out_ext_n;
      frame_err    <= frame_err_n;
      if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
      if (err_inc)   err_cnt   <= err_cnt + 16'd1;
    end
  end

  assign io_frame_count = frame_cnt;
  assign io_err_count   = err_cnt;

endmodule

// File: tb/tb_encoder_rx_decoder.sv
// tb/tb_encoder_rx_decoder.sv - directed checks of PAM5 rx framing, latency, abort and counters
module tb_encoder_rx_decoder;

  localparam logic [2:0] Z  = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;
  localparam logic [2:0] M1 = 3'b111;
  localparam logic [2:0] M2 = 3'b110;

  localparam logic [11:0] Q_SSD1   = {P2, P2, P2, P2};
  localparam logic [11:0] Q_SSD2   = {P2, P2, P2, M2};
  localparam logic [11:0] Q_EXT1   = {P2, P2, M2, P2};
  localparam logic [11:0] Q_EXT2   = {P2, M2, P2, P2};
  localparam logic [11:0] Q_EXTERR = {M2, P2, P2, P2};
  localparam logic [11:0] Q_IDLE   = {Z, Z, Z, Z};
  localparam logic [11:0] Q_A5     = {M1, M1, P1, P1};
  localparam logic [11:0] Q_01     = {Z, Z, Z, P1};
  localparam logic [11:0] Q_12     = {Z, P1, Z, M1};
  localparam logic [11:0] Q_3C     = {Z, P2, P2, Z};
  localparam logic [11:0] Q_BAD    = {3'b011, Z, Z, Z};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  io_A = 3'b000, io_B = 3'b000, io_C = 3'b000, io_D = 3'b000;
  logic        io_loc_rcvr_status = 1'b1;
  logic        io_rx_dv, io_rx_er, io_frame_end;
  logic [7:0]  io_rx_data;
  logic [1:0]  io_ext;
  logic [15:0] io_frame_count, io_err_count;

  encoder_rx_decoder dut (
    .clock              (clock),
    .reset              (reset),
    .io_A               (io_A),
    .io_B               (io_B),
    .io_C               (io_C),
    .io_D               (io_D),
    .io_loc_rcvr_status (io_loc_rcvr_status),
    .io_rx_dv           (io_rx_dv),
    .io_rx_er           (io_rx_er),
    .io_rx_data         (io_rx_data),
    .io_frame_end       (io_frame_end),
    .io_ext             (io_ext),
    .io_frame_count     (io_frame_count),
    .io_err_count       (io_err_count)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  logic [9:0]  rec_q[$];
  logic [1:0]  fe_q[$];
  int          dv_runs = 0;
  int          fe_dv = 0;
  logic        prev_dv = 1'b0;
  logic [11:0] seq[$];
  logic [15:0] exp_fc = 16'd0;
  logic [15:0] exp_ec = 16'd0;

  always @(negedge clock) begin
    if (io_rx_dv || io_rx_er) rec_q.push_back({io_rx_dv, io_rx_er, io_rx_data});
    if (io_frame_end) begin
      fe_q.push_back(io_ext);
      if (io_rx_dv) fe_dv++;
    end
    if (io_rx_dv && !prev_dv) dv_runs++;
    prev_dv = io_rx_dv;
  end

  task automatic step(input logic [11:0] q, input logic ok);
    {io_A, io_B, io_C, io_D} = q;
    io_loc_rcvr_status = ok;
    @(posedge clock);
    #1;
  endtask

  task automatic play();
    foreach (seq[i]) step(seq[i], 1'b1);
    repeat (4) step(Q_IDLE, 1'b1);
  endtask

  task automatic clear_logs();
    rec_q.delete();
    fe_q.delete();
    dv_runs = 0;
    fe_dv = 0;
  endtask

  task automatic check_counters(input string tag);
    checks++;
    if (io_frame_count !== exp_fc) begin
      failures++;
      $display("FAIL %s frame_count: got %h want %h", tag, io_frame_count, exp_fc);
    end
    checks++;
    if (io_err_count !== exp_ec) begin
      failures++;
      $display("FAIL %s err_count: got %h want %h", tag, io_err_count, exp_ec);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step(Q_SSD1, 1'b1);
    checks++;
    if ({io_rx_dv, io_rx_er, io_rx_data, io_frame_end, io_ext} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0", {io_rx_dv, io_rx_er, io_rx_data, io_frame_end, io_ext});
    end
    check_counters("reset");
    reset = 1'b1;
  endtask

  task automatic test_latency_a5();
    clear_logs();
    step(Q_SSD1, 1'b1);
    step(Q_SSD2, 1'b1);
    step(Q_A5, 1'b1);
    step(Q_IDLE, 1'b1);
    checks++;
    if (io_rx_dv !== 1'b0) begin
      failures++;
      $display("FAIL a5_early_dv: got %b want 0", io_rx_dv);
    end
    step(Q_SSD1, 1'b1);
    checks++;
    if ({io_rx_dv, io_rx_er, io_rx_data} !== {2'b10, 8'hA5}) begin
      failures++;
      $display("FAIL a5_byte0: got %b want %b", {io_rx_dv, io_rx_er, io_rx_data}, {2'b10, 8'hA5});
    end
    step(Q_SSD2, 1'b1);
    checks++;
    if ({io_rx_dv, io_rx_er, io_rx_data} !== {2'b10, 8'h00}) begin
      failures++;
      $display("FAIL a5_byte1: got %b want %b", {io_rx_dv, io_rx_er, io_rx_data}, {2'b10, 8'h00});
    end
    step(Q_IDLE, 1'b1);
    checks++;
    if ({io_frame_end, io_ext, io_rx_dv} !== 4'b1000) begin
      failures++;
      $display("FAIL a5_frame_end: got %b want 1000", {io_frame_end, io_ext, io_rx_dv});
    end
    step(Q_IDLE, 1'b1);
    checks++;
    if (io_frame_end !== 1'b0 || dv_runs != 1) begin
      failures++;
      $display("FAIL a5_pulse_runs: got fe=%b runs=%0d want fe=0 runs=1", io_frame_end, dv_runs);
    end
    exp_fc = 16'd1;
    check_counters("a5");
  endtask

  task automatic test_held_ff();
    clear_logs();
    seq = '{Q_SSD1, Q_SSD2, Q_SSD1, Q_01, Q_SSD1, Q_EXT2};
    play();
    checks++;
    if (rec_q.size() != 2 || rec_q[0] !== {2'b10, 8'hFF} || rec_q[1] !== {2'b10, 8'h01}) begin
      failures++;
      $display("FAIL ff01_bytes: got n=%0d %p want FF,01", rec_q.size(), rec_q);
    end
    checks++;
    if (fe_q.size() != 1 || fe_q[0] !== 2'd2) begin
      failures++;
      $display("FAIL ff01_ext: got %p want 2", fe_q);
    end
    checks++;
    if (dv_runs != 1 || fe_dv != 0) begin
      failures++;
      $display("FAIL ff01_dv_shape: got runs=%0d fe_dv=%0d want 1 0", dv_runs, fe_dv);
    end
    exp_fc = 16'd2;
    check_counters("ff01");
  endtask

  task automatic test_error_frame();
    clear_logs();
    seq = '{Q_SSD1, Q_SSD2, Q_BAD, Q_SSD1, Q_EXTERR};
    play();
    checks++;
    if (rec_q.size() != 1 || rec_q[0][8:0] !== {1'b1, 8'h00}) begin
      failures++;
      $display("FAIL err_byte: got n=%0d %p want er=1 data=00", rec_q.size(), rec_q);
    end
    checks++;
    if (fe_q.size() != 1 || fe_q[0] !== 2'd3) begin
      failures++;
      $display("FAIL err_ext: got %p want 3", fe_q);
    end
    exp_ec = 16'd1;
    check_counters("err");
  endtask

  task automatic test_abort();
    clear_logs();
    step(Q_SSD1, 1'b1);
    step(Q_SSD2, 1'b1);
    step(Q_12, 1'b0);
    repeat (4) step(Q_IDLE, 1'b1);
    checks++;
    if (rec_q.size() != 1 || rec_q[0] !== {2'b01, 8'h00} || dv_runs != 0) begin
      failures++;
      $display("FAIL abort_output: got n=%0d %p runs=%0d want one er-only", rec_q.size(), rec_q, dv_runs);
    end
    checks++;
    if (fe_q.size() != 0) begin
      failures++;
      $display("FAIL abort_no_end: got %0d frame ends want 0", fe_q.size());
    end
    exp_ec = 16'd2;
    check_counters("abort");
  endtask

  task automatic test_ssd_repeat();
    clear_logs();
    seq = '{Q_SSD1, Q_SSD1, Q_SSD2, Q_3C, Q_SSD1, Q_EXT1};
    play();
    checks++;
    if (rec_q.size() != 1 || rec_q[0] !== {2'b10, 8'h3C}) begin
      failures++;
      $display("FAIL ssd_rep_byte: got n=%0d %p want 3C", rec_q.size(), rec_q);
    end
    checks++;
    if (fe_q.size() != 1 || fe_q[0] !== 2'd1) begin
      failures++;
      $display("FAIL ssd_rep_ext: got %p want 1", fe_q);
    end
    exp_fc = 16'd3;
    check_counters("ssd_rep");
    clear_logs();
    seq = '{Q_SSD1, Q_IDLE};
    play();
    checks++;
    if (rec_q.size() != 0 || dv_runs != 0 || fe_q.size() != 0) begin
      failures++;
      $display("FAIL ssd_no_start: got n=%0d runs=%0d fe=%0d want 0", rec_q.size(), dv_runs, fe_q.size());
    end
  endtask

  task automatic test_async_reset();
    clear_logs();
    step(Q_SSD1, 1'b1);
    step(Q_SSD2, 1'b1);
    step(Q_A5, 1'b1);
    step(Q_A5, 1'b1);
    step(Q_A5, 1'b1);
    checks++;
    if (io_rx_dv !== 1'b1) begin
      failures++;
      $display("FAIL async_pre_dv: got %b want 1", io_rx_dv);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (io_rx_dv !== 1'b0) begin
      failures++;
      $display("FAIL async_dv_drop: got %b want 0", io_rx_dv);
    end
    exp_fc = 16'd0;
    exp_ec = 16'd0;
    check_counters("async");
    repeat (2) step(Q_IDLE, 1'b1);
    reset = 1'b1;
    repeat (3) step(Q_IDLE, 1'b1);
    checks++;
    if (fe_q.size() != 0) begin
      failures++;
      $display("FAIL async_no_end: got %0d frame ends want 0", fe_q.size());
    end
  endtask

  task automatic test_wrap();
    #2 dut.frame_cnt = 16'hFFFE;
    seq = '{Q_SSD1, Q_SSD2, Q_SSD1, Q_IDLE};
    seq.push_back(Q_SSD1);
    seq.push_back(Q_SSD2);
    play();
    exp_fc = 16'hFFFF;
    check_counters("wrap_ffff");
    play();
    exp_fc = 16'h0000;
    check_counters("wrap_zero");
  endtask

  initial begin
    test_reset();
    test_latency_a5();
    test_held_ff();
    test_error_frame();
    test_abort();
    test_ssd_repeat();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
